fir_csa_pipe_subtractor: RTL
============================

# fir_csa_pipe_subtractor

Pipelined signed subtractor for the FIR datapath. It computes `in1 - in2` on DATA_WIDTH-bit two's-complement operands as a chain of 2-bit carry-select slices, with one slice resolved per clock stage. It sits directly downstream of the 2-bit carry-select subtractor slices, registering and chaining their carries into a full-width difference. A valid/ready handshake with global stall lets it feed the tap accumulator under backpressure.

## Interface
- `DATA_WIDTH`, default 8: operand width.
  - Must be even and ≥ 4.
  - Number of stages `S = DATA_WIDTH/2`.
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `in_valid`, in, 1: operand pair present.
- `in_ready`, out, 1: block accepts an operand pair this cycle.
- `in1`, in, DATA_WIDTH: minuend, signed.
- `in2`, in, DATA_WIDTH: subtrahend, signed.
- `out_valid`, out, 1: `out_diff` holds a result.
- `out_ready`, in, 1: consumer accepts the result.
- `out_diff`, out, DATA_WIDTH+1: signed `in1 - in2`, full precision, never overflows.

## Operation
**Arithmetic**
- `diff = sext(in1) + ~sext(in2) + 1`, computed at DATA_WIDTH+1 bits.
- Carry-in to slice 0 is 1.

**Slices**
- Slice k covers bits `[2k+1:2k]`, with k = 0..S-1.
- Each slice precomputes two 2-bit sums plus carry-out: one for carry-in 0, one for carry-in 1.
- It selects between them with the carry registered by stage k-1.

**Pipeline**
- Stage k registers:
  - resolved difference bits `[2k+1:0]`;
  - carry-out of slice k;
  - operand bits above slice k, delayed unchanged;
  - a per-stage valid bit.
- The last stage also forms bit DATA_WIDTH:
  - `in1[MSB] ^ ~in2[MSB] ^ carry_out(slice S-1)`.
  - This is equivalent to the sign-extension bit of the sum.

**Handshake / stall**
- `adv = !out_valid || out_ready`. All stage registers load only when `adv = 1`.
- `in_ready = adv`, combinational.
- Accept when `in_valid && in_ready`.
- If `in_valid = 0` while `adv = 1`, a bubble (valid 0) enters stage 0. Bubbles are not collapsed.
- Output transfer occurs when `out_valid && out_ready`.
- If `out_valid = 1` and `out_ready = 0`, every stage holds. `out_diff` and `out_valid` are stable and no operand pair is accepted.
- Simultaneous output transfer and input accept in the same cycle is legal and occurs at full throughput.

**Reset**
- All valid bits, `out_valid`, `out_diff` and all data/carry registers are 0.
- `in_ready` = 1 during and after reset, because `out_valid` = 0.
- Reset asserted mid-stream discards all in-flight transactions immediately, asynchronously.

## Timing
- Latency: S cycles from the accept edge to `out_valid` high, with no stall. DATA_WIDTH = 8 gives 4 cycles.
- Throughput: one result per cycle while `out_ready` is held 1.
- Each stall cycle adds exactly one cycle of latency to every in-flight transaction.
- Ordering is strictly FIFO. No drops, no duplicates.
- Critical path per stage: one 2-bit slice add plus a 3-bit 2:1 select.

## Test plan
All cases use DATA_WIDTH = 8 with `out_ready` = 1 unless stated.

- **Basic difference:** `in1=100, in2=37`, single accept → 4 cycles later `out_valid=1`, `out_diff=9'h03F` (63) for one cycle; then `out_valid=0`.
- **Extremes:**
  - `in1=-128, in2=127` → `out_diff=9'h101` (-255).
  - `in1=127, in2=-128` → `9'h0FF` (255).
  - `in1=0, in2=0` → `9'h000`.
- **Full-rate stream:** accept (5,3), (−1,1), (−8,−8), (64,−64) on consecutive cycles → results 2, −2, 0, 128 (`9'h002, 9'h1FE, 9'h000, 9'h080`) on 4 consecutive cycles starting at cycle 4.
- **Backpressure:** pipeline full, `out_ready=0` for 3 cycles → `in_ready=0`, `out_diff` constant, no stage changes. On release, the remaining results emerge in order with none lost or repeated.
- **Bubbles:** accept, idle 2 cycles, accept → two results separated by exactly 2 idle `out_valid=0` cycles.
- **Reset mid-operation:** assert `rst` with 3 results in flight → `out_valid=0`, `out_diff=0`, `in_ready=1` immediately. After deassert, nothing emerges until a new accept, which yields its result after 4 cycles.

Source files
------------

// File: rtl/fir_csa_pipe_subtractor.sv
// Pipelined signed subtractor: in1 - in2 resolved two bits per stage with carry-select slices,
// full-precision DATA_WIDTH+1 result, valid/ready handshake with a global stall.
module fir_csa_pipe_subtractor #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   out_diff
);

    localparam int W = DATA_WIDTH;
    localparam int S = DATA_WIDTH / 2;

    // Both candidate sums are formed up front; the registered carry only drives the final select.
    function automatic logic [2:0] sliceSel(input logic [1:0] a, input logic [1:0] b, input logic cin);
        logic [2:0] sum0;
        logic [2:0] sum1;
        sum0 = {1'b0, a} + {1'b0, ~b};
        sum1 = sum0 + 3'd1;
        return cin ? sum1 : sum0;
    endfunction

    logic         adv;
    logic [2:0]   sliceRes [S];
    logic [W-1:0] diff_q   [S];
    logic [W-1:0] diff_d   [S];
    logic [W-1:0] opA_q    [S-1];
    logic [W-1:0] opA_d    [S-1];
    logic [W-1:0] opB_q    [S-1];
    logic [W-1:0] opB_d    [S-1];
    logic [S-2:0] carry_q;
    logic [S-2:0] carry_d;
    logic [S-1:0] valid_q;
    logic [S-1:0] valid_d;
    logic         msb_q;
    logic         msb_d;

    assign out_valid = valid_q[S-1];
    assign out_diff  = {msb_q, diff_q[S-1]};
    assign in_ready  = adv;

    always_comb begin
        adv = !valid_q[S-1] || out_ready;

        sliceRes[0] = sliceSel(in1[1:0], in2[1:0], 1'b1);
        diff_d[0]   = '0;
        diff_d[0][1:0] = sliceRes[0][1:0];
        valid_d[0]  = in_valid;
        opA_d[0]    = in1;
        opB_d[0]    = in2;

        for (int k = 1; k < S; k++) begin
            sliceRes[k] = sliceSel(opA_q[k-1][2*k +: 2], opB_q[k-1][2*k +: 2], carry_q[k-1]);
            diff_d[k]   = diff_q[k-1];
            diff_d[k][2*k +: 2] = sliceRes[k][1:0];
            valid_d[k]  = valid_q[k-1];
        end

        for (int k = 1; k < S-1; k++) begin
            opA_d[k] = opA_q[k-1];
            opB_d[k] = opB_q[k-1];
        end

        for (int k = 0; k < S-1; k++) begin
            carry_d[k] = sliceRes[k][2];
        end

        // Sign-extension bit of sext(in1) + ~sext(in2) + 1, formed alongside the top slice.
        msb_d = opA_q[S-2][W-1] ^ ~opB_q[S-2][W-1] ^ sliceRes[S-1][2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            msb_q   <= 1'b0;
            for (int k = 0; k < S; k++) begin
                diff_q[k] <= '0;
            end
            for (int k = 0; k < S-1; k++) begin
                opA_q[k] <= '0;
                opB_q[k] <= '0;
            end
        end else if (adv) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            msb_q   <= msb_d;
            for (int k = 0; k < S; k++) begin
                diff_q[k] <= diff_d[k];
            end
            for (int k = 0; k < S-1; k++) begin
                opA_q[k] <= opA_d[k];
                opB_q[k] <= opB_d[k];
            end
        end
    end

endmodule
